// File: rtl/slv_fsm_tmo_if.sv
// Access handshake between a bus master and the slv_fsm_tmo slave responder.
// The master drives request/control signals; the slave returns the acknowledge and read data.
interface slv_fsm_tmo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  if_soft_rst;
  logic                  if_req_vld;
  logic                  if_wr_en;
  logic                  if_rd_en;
  logic                  if_err_en;
  logic                  if_ack_vld;
  logic [DATA_WIDTH-1:0] if_rd_data;
  logic                  if_err;
  logic                  if_busy;

  modport master (
    output if_soft_rst, if_req_vld, if_wr_en, if_rd_en, if_err_en,
    input  if_ack_vld, if_rd_data, if_err, if_busy
  );

  modport slave (
    input  if_soft_rst, if_req_vld, if_wr_en, if_rd_en, if_err_en,
    output if_ack_vld, if_rd_data, if_err, if_busy
  );
endinterface

// File: rtl/slv_fsm_tmo.sv
// Slave access FSM: acknowledges dummy/register accesses immediately or after a wait,
// and aborts waiting accesses with an error acknowledge once the wait counter hits tmo_thr.
module slv_fsm_tmo #(
  parameter int DATA_WIDTH = 32,
  parameter int TMO_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  slv_fsm_tmo_if.slave          bus,
  input  logic                  dummy_acc,
  input  logic                  reg_acc,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_data_vld,
  input  logic [TMO_WIDTH-1:0]  tmo_thr,
  output logic                  tmo_evt
);

  typedef enum logic [2:0] {
    IDLE,
    DUMMY_ACK,
    REG_WR_ACK,
    REG_RD_ACK,
    WR_ACC,
    RD_ACC,
    TMO_ACK
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [TMO_WIDTH-1:0]  wait_cnt;
  logic [DATA_WIDTH-1:0] rd_cap;
  logic                  wr_done;
  logic                  rd_done;
  logic                  tmo_hit;

  // Dummy hits complete a waiting access in either direction.
  assign wr_done = dummy_acc | reg_acc;
  assign rd_done = dummy_acc | reg_rd_data_vld;
  assign tmo_hit = (tmo_thr != '0) && (wait_cnt == tmo_thr);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the capture register is a plain flop, not a memory, so it is reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      rd_cap   <= '0;
    end else if (bus.if_soft_rst) begin
      wait_cnt <= '0;
      rd_cap   <= '0;
    end else begin
      if (state != WR_ACC && state != RD_ACC) begin
        wait_cnt <= '0;
      end else if (!((state == WR_ACC) ? wr_done : rd_done) && wait_cnt != '1) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == IDLE && state_nxt == REG_RD_ACK) begin
        rd_cap <= reg_rd_data;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.if_req_vld && bus.if_wr_en) begin
          if (dummy_acc)    state_nxt = DUMMY_ACK;
          else if (reg_acc) state_nxt = REG_WR_ACK;
          else              state_nxt = WR_ACC;
        end else if (bus.if_req_vld && bus.if_rd_en) begin
          if (dummy_acc)            state_nxt = DUMMY_ACK;
          else if (reg_rd_data_vld) state_nxt = REG_RD_ACK;
          else                      state_nxt = RD_ACC;
        end
      end
      DUMMY_ACK, REG_WR_ACK, REG_RD_ACK, TMO_ACK: state_nxt = IDLE;
      WR_ACC: begin
        if (wr_done)      state_nxt = IDLE;
        else if (tmo_hit) state_nxt = TMO_ACK;
      end
      RD_ACC: begin
        if (rd_done)      state_nxt = IDLE;
        else if (tmo_hit) state_nxt = TMO_ACK;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.if_soft_rst) state_nxt = IDLE;
  end

  assign bus.if_busy = (state != IDLE);

  always_comb begin
    bus.if_ack_vld = 1'b0;
    bus.if_err     = 1'b0;
    bus.if_rd_data = '0;
    tmo_evt        = 1'b0;
    if (!bus.if_soft_rst) begin
      case (state)
        DUMMY_ACK: begin
          bus.if_ack_vld = 1'b1;
          bus.if_err     = bus.if_err_en;
        end
        REG_WR_ACK: bus.if_ack_vld = 1'b1;
        REG_RD_ACK: begin
          bus.if_ack_vld = 1'b1;
          bus.if_rd_data = rd_cap;
        end
        TMO_ACK: begin
          bus.if_ack_vld = 1'b1;
          bus.if_err     = 1'b1;
          tmo_evt        = 1'b1;
        end
        WR_ACC: begin
          if (dummy_acc) begin
            bus.if_ack_vld = 1'b1;
            bus.if_err     = bus.if_err_en;
          end else if (reg_acc) begin
            bus.if_ack_vld = 1'b1;
          end
        end
        RD_ACC: begin
          if (dummy_acc) begin
            bus.if_ack_vld = 1'b1;
            bus.if_err     = bus.if_err_en;
          end else if (reg_rd_data_vld) begin
            bus.if_ack_vld = 1'b1;
            bus.if_rd_data = reg_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slv_fsm_tmo.sv
// Self-checking bench for slv_fsm_tmo: expected acknowledges are queued when stimulus is
// driven and compared (cycle, data, err, tmo_evt) when the DUT raises if_ack_vld.
module tb_slv_fsm_tmo;

  localparam int DW = 32;
  localparam int TW = 8;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
    logic        tmo;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dummy_acc;
  logic          reg_acc;
  logic [DW-1:0] reg_rd_data;
  logic          reg_rd_data_vld;
  logic [TW-1:0] tmo_thr;
  logic          tmo_evt;

  int   n_checks = 0;
  int   n_errors = 0;
  int   ncyc     = 0;
  exp_t sb[$];
  exp_t e;

  slv_fsm_tmo_if #(.DATA_WIDTH(DW)) bus ();

  slv_fsm_tmo #(.DATA_WIDTH(DW), .TMO_WIDTH(TW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .dummy_acc      (dummy_acc),
    .reg_acc        (reg_acc),
    .reg_rd_data    (reg_rd_data),
    .reg_rd_data_vld(reg_rd_data_vld),
    .tmo_thr        (tmo_thr),
    .tmo_evt        (tmo_evt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    ncyc++;
    if (bus.if_ack_vld) begin
      if (sb.size() == 0) begin
        check("unexp_ack", 64'(bus.if_ack_vld), 64'd0);
      end else begin
        e = sb.pop_front();
        check("ack_cyc",  64'(ncyc), 64'(e.cyc));
        check("ack_data", 64'(bus.if_rd_data), 64'(e.data));
        check("ack_err",  64'(bus.if_err), 64'(e.err));
        check("ack_tmo",  64'(tmo_evt), 64'(e.tmo));
      end
    end else begin
      check("quiet", {bus.if_rd_data, bus.if_err, tmo_evt}, 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expect an ack 'lat' cycles after the cycle currently being driven.
  task automatic push(input int lat, input logic [31:0] data, input logic err, input logic tmo);
    sb.push_back('{cyc: ncyc + 1 + lat, data: data, err: err, tmo: tmo});
  endtask

  task automatic drive_req(input logic wr, input logic rd, input logic dm, input logic ra,
                           input logic rv, input logic [31:0] rdd);
    bus.if_req_vld  = 1'b1;
    bus.if_wr_en    = wr;
    bus.if_rd_en    = rd;
    dummy_acc       = dm;
    reg_acc         = ra;
    reg_rd_data_vld = rv;
    reg_rd_data     = rdd;
    step();
    bus.if_req_vld  = 1'b0;
    bus.if_wr_en    = 1'b0;
    bus.if_rd_en    = 1'b0;
    dummy_acc       = 1'b0;
    reg_acc         = 1'b0;
    reg_rd_data_vld = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.if_soft_rst = 1'b0;
    bus.if_req_vld  = 1'b0;
    bus.if_wr_en    = 1'b0;
    bus.if_rd_en    = 1'b0;
    bus.if_err_en   = 1'b0;
    dummy_acc       = 1'b0;
    reg_acc         = 1'b0;
    reg_rd_data     = '0;
    reg_rd_data_vld = 1'b0;
    tmo_thr         = '0;
    step();
    step();
    check("rst_ack",  64'(bus.if_ack_vld), 64'd0);
    check("rst_busy", 64'(bus.if_busy), 64'd0);
    check("rst_err",  64'(bus.if_err), 64'd0);
    check("rst_tmo",  64'(tmo_evt), 64'd0);
    check("rst_data", 64'(bus.if_rd_data), 64'd0);

    // Register write accepted in the very first cycle after reset release.
    rst_n = 1'b1;
    push(1, 32'h0, 1'b0, 1'b0);
    drive_req(1, 0, 0, 1, 0, 32'h0);
    check("wr_busy_ack", 64'(bus.if_busy), 64'd1);
    step();
    check("wr_busy_idle", 64'(bus.if_busy), 64'd0);

    // Immediate register read: captured data survives a change of reg_rd_data.
    push(1, 32'hA5A5_0001, 1'b0, 1'b0);
    drive_req(0, 1, 0, 0, 1, 32'hA5A5_0001);
    reg_rd_data = 32'hDEAD_BEEF;
    step();

    // Write wins over read when both enables are set.
    push(1, 32'h0, 1'b0, 1'b0);
    drive_req(1, 1, 0, 1, 1, 32'h1111_2222);
    step();

    // Request with no enable stays idle.
    drive_req(0, 0, 1, 1, 1, 32'h3333_4444);
    check("noen_busy", 64'(bus.if_busy), 64'd0);
    step();

    // Dummy writes with err_en on, then off.
    bus.if_err_en = 1'b1;
    push(1, 32'h0, 1'b1, 1'b0);
    drive_req(1, 0, 1, 0, 0, 32'h0);
    step();
    bus.if_err_en = 1'b0;
    push(1, 32'h0, 1'b0, 1'b0);
    drive_req(1, 0, 1, 0, 0, 32'h0);
    step();

    // Dummy read beats reg_rd_data_vld; read data forced to zero.
    bus.if_err_en = 1'b1;
    push(1, 32'h0, 1'b1, 1'b0);
    drive_req(0, 1, 1, 0, 1, 32'h5555_5555);
    step();
    bus.if_err_en = 1'b0;

    // Waiting write completed by reg_acc two cycles into WR_ACC.
    drive_req(1, 0, 0, 0, 0, 32'h0);
    step();
    step();
    reg_acc = 1'b1;
    push(0, 32'h0, 1'b0, 1'b0);
    step();
    reg_acc = 1'b0;
    check("wacc_done_busy", 64'(bus.if_busy), 64'd0);

    // Waiting read completed by reg_rd_data_vld.
    drive_req(0, 1, 0, 0, 0, 32'h0);
    step();
    reg_rd_data_vld = 1'b1;
    reg_rd_data     = 32'h1234_5678;
    push(0, 32'h1234_5678, 1'b0, 1'b0);
    step();
    reg_rd_data_vld = 1'b0;

    // Waiting read: dummy and vld together -> dummy completion, zero data.
    drive_req(0, 1, 0, 0, 0, 32'h0);
    dummy_acc       = 1'b1;
    reg_rd_data_vld = 1'b1;
    reg_rd_data     = 32'h7777_7777;
    push(0, 32'h0, 1'b0, 1'b0);
    step();
    dummy_acc       = 1'b0;
    reg_rd_data_vld = 1'b0;

    // Read timeout with tmo_thr=4: error ack 6 cycles after the request.
    tmo_thr = 8'd4;
    push(6, 32'h0, 1'b1, 1'b1);
    drive_req(0, 1, 0, 0, 0, 32'h0);
    repeat (7) step();

    // Completion at wait count 4 wins over the timeout.
    drive_req(0, 1, 0, 0, 0, 32'h0);
    repeat (4) step();
    reg_rd_data_vld = 1'b1;
    reg_rd_data     = 32'h0BAD_F00D;
    push(0, 32'h0BAD_F00D, 1'b0, 1'b0);
    step();
    reg_rd_data_vld = 1'b0;
    step();

    // Write timeout at the smallest non-zero threshold, err_en ignored.
    tmo_thr = 8'd1;
    push(3, 32'h0, 1'b1, 1'b1);
    drive_req(1, 0, 0, 0, 0, 32'h0);
    repeat (4) step();

    // Soft reset coincident with read completion: no ack, idle next cycle.
    tmo_thr = 8'd0;
    drive_req(0, 1, 0, 0, 0, 32'h0);
    step();
    bus.if_soft_rst = 1'b1;
    reg_rd_data_vld = 1'b1;
    reg_rd_data     = 32'hCAFE_0000;
    #1;
    check("srst_ack", 64'(bus.if_ack_vld), 64'd0);
    step();
    bus.if_soft_rst = 1'b0;
    reg_rd_data_vld = 1'b0;
    check("srst_busy", 64'(bus.if_busy), 64'd0);

    // After the abort, a fresh timeout with tmo_thr=2 runs from a cleared counter.
    tmo_thr = 8'd2;
    push(4, 32'h0, 1'b1, 1'b1);
    drive_req(0, 1, 0, 0, 0, 32'h0);
    repeat (5) step();

    // Timeout disabled: counter saturates, no ack; hard reset clears everything at once.
    tmo_thr = 8'd0;
    drive_req(0, 1, 0, 0, 0, 32'h0);
    repeat (300) step();
    check("sat_busy", 64'(bus.if_busy), 64'd1);
    check("sat_cnt",  64'(dut.wait_cnt), 64'd255);
    reg_rd_data = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    #1;
    check("hrst_ack",  64'(bus.if_ack_vld), 64'd0);
    check("hrst_busy", 64'(bus.if_busy), 64'd0);
    check("hrst_err",  64'(bus.if_err), 64'd0);
    check("hrst_tmo",  64'(tmo_evt), 64'd0);
    check("hrst_data", 64'(bus.if_rd_data), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/slv_fsm_tmo.md
SLV_FSM_TMO -- requirements
Module: slv_fsm_tmo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, read data width in bits.
REQ-002 SHALL have parameter TMO_WIDTH, default 8, width of the timeout threshold and of the wait counter.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port if_soft_rst, input, 1 bit, synchronous soft reset.
REQ-006 SHALL have port if_req_vld, input, 1 bit, access request strobe.
REQ-007 SHALL have ports if_wr_en and if_rd_en, input, 1 bit each, access direction.
REQ-008 SHALL have port if_err_en, input, 1 bit, enables if_err on dummy acknowledge.
REQ-009 SHALL have ports dummy_acc and reg_acc, input, 1 bit each, dummy-hit and register-write-complete indications.
REQ-010 SHALL have ports reg_rd_data (input, DATA_WIDTH) and reg_rd_data_vld (input, 1 bit), register read return.
REQ-011 SHALL have port tmo_thr, input, TMO_WIDTH bits, wait-cycle timeout threshold; 0 disables timeout.
REQ-012 SHALL have ports if_ack_vld (output, 1), if_rd_data (output, DATA_WIDTH) and if_err (output, 1), the access response.
REQ-013 SHALL have port if_busy, output, 1 bit, high in every state other than IDLE.
REQ-014 SHALL have port tmo_evt, output, 1 bit, one-cycle pulse when an access times out.

Function
REQ-015 SHALL implement states IDLE, DUMMY_ACK, REG_WR_ACK, REG_RD_ACK, WR_ACC, RD_ACC and TMO_ACK.
REQ-016 SHALL, in IDLE with if_req_vld=1 and if_wr_en=1, go to DUMMY_ACK if dummy_acc, else REG_WR_ACK if reg_acc, else WR_ACC; if_wr_en takes priority over if_rd_en.
REQ-017 SHALL, in IDLE with if_req_vld=1, if_wr_en=0 and if_rd_en=1, go to DUMMY_ACK if dummy_acc, else REG_RD_ACK if reg_rd_data_vld, else RD_ACC.
REQ-018 SHALL stay in IDLE when if_req_vld=0 or when neither enable is set; if_req_vld outside IDLE is ignored.
REQ-019 SHALL return from DUMMY_ACK, REG_WR_ACK, REG_RD_ACK and TMO_ACK to IDLE after exactly one cycle.
REQ-020 SHALL capture reg_rd_data into an internal DATA_WIDTH register on the IDLE->REG_RD_ACK transition and drive it on if_rd_data in REG_RD_ACK.
REQ-021 SHALL, in WR_ACC, complete in the same cycle as dummy_acc or reg_acc: if_ack_vld=1 combinationally and next state IDLE.
REQ-022 SHALL, in RD_ACC, complete in the same cycle as dummy_acc or reg_rd_data_vld: if_ack_vld=1, if_rd_data=reg_rd_data (zero on dummy completion), next state IDLE.
REQ-023 SHALL assert if_err=if_err_en with if_ack_vld on any dummy completion; dummy_acc takes priority over reg_acc or reg_rd_data_vld in the same cycle.
REQ-024 SHALL clear a TMO_WIDTH wait counter on entry to WR_ACC or RD_ACC and increment it by one each non-completing cycle spent there, saturating at all-ones.
REQ-025 SHALL, when tmo_thr!=0, go to TMO_ACK when the wait counter equals tmo_thr in a cycle with no completion; completion in that same cycle wins.
REQ-026 SHALL drive if_ack_vld=1, if_err=1 (independent of if_err_en), if_rd_data=0 and tmo_evt=1 in TMO_ACK.
REQ-027 SHALL drive if_rd_data to zero whenever if_ack_vld=0 or the acknowledged access is not a register read.
REQ-028 SHALL keep if_ack_vld, if_err and tmo_evt at 0 in every state and cycle not listed above.
REQ-029 SHALL, on if_soft_rst=1, force if_ack_vld, if_err and tmo_evt to 0 in that cycle and return to IDLE with the counter and capture register cleared on the next edge, aborting any access in progress.

Reset
REQ-030 SHALL, while rst_n=0, set state IDLE, wait counter 0, capture register 0, and all outputs 0 (if_busy=0).
REQ-031 SHALL accept a request in the first cycle after rst_n deasserts.

Verification
REQ-032 Write with reg_acc=1 in the request cycle -> if_ack_vld=1 exactly one cycle later, if_err=0, if_busy=1 for that one cycle.
REQ-033 Read with reg_rd_data_vld=1, reg_rd_data=0xA5A5_0001 -> next cycle if_ack_vld=1, if_rd_data=0xA5A5_0001 even if reg_rd_data changes meanwhile.
REQ-034 Read, tmo_thr=4, no response -> if_ack_vld=1, if_err=1, tmo_evt=1 exactly 6 cycles after the request; reg_rd_data_vld at wait count 4 -> normal ack, no tmo_evt.
REQ-035 Write to dummy address with if_err_en=1, then with if_err_en=0 -> if_err=1 then 0, each with a one-cycle ack.
REQ-036 if_soft_rst pulsed in RD_ACC coincident with reg_rd_data_vld -> no ack that cycle, IDLE next cycle, if_busy=0.
REQ-037 tmo_thr=0 with no response for 300 cycles -> stays in RD_ACC, counter saturates at 255, no ack; rst_n asserted mid-access -> all outputs 0 immediately.
